// File: rtl/baud_serial_tx_pkg.sv
// Shared state encoding and line-level constants for the baud-referenced serial transmitter.
// Latency: n/a (types only). Backpressure: n/a.
package baud_serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/baud_tick_detect.sv
// Rising-edge detector on the generator square wave, sampled as data in the Clock domain.
// Latency: tick is combinational from BaudClk, one cycle wide. Backpressure: none.
module baud_tick_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic BaudClk,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= BaudClk;
    end
  end

  assign tick = BaudClk & ~baud_q;

endmodule

// File: rtl/baud_serial_tx.sv
// LSB-first start/data/parity/stop serializer paced by BaudClk ticks, one-entry holding register.
// Latency: frame starts on first tick after accept. Backpressure: TxReady low while holding register full.
module baud_serial_tx
  import baud_serial_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 BaudClk,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  output logic                 TxOut,
  output logic                 Busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic                 tick;
  logic                 accept;
  logic                 load;
  logic                 hold_full;
  logic                 hold_full_nxt;
  logic                 par_bit;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] hold_dat;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;

  baud_tick_detect u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .BaudClk(BaudClk),
    .tick   (tick)
  );

  assign accept = TxValid && TxReady;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            state_nxt = START;
            load      = 1'b1;
          end
        end
        START:  state_nxt = DATA;
        DATA: begin
          if (bit_cnt == CW'(DATA_BITS)) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: state_nxt = STOP;
        STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            // A waiting byte chains straight into the next start bit.
            if (hold_full) begin
              state_nxt = START;
              load      = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_dat  <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      TxOut     <= LINE_IDLE;
      TxReady   <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      TxReady   <= ~hold_full_nxt;
      Busy      <= (state_nxt != IDLE) || hold_full_nxt;
      if (accept) begin
        hold_dat <= TxData;
      end
      if (load) begin
        shift   <= hold_dat;
        par_bit <= (^hold_dat) ^ 1'(PARITY_ODD);
      end
      if (tick) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        case (state_nxt)
          START:  TxOut <= START_BIT;
          DATA: begin
            TxOut   <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= (state == DATA) ? bit_cnt + CW'(1) : CW'(1);
          end
          PARITY: TxOut <= par_bit;
          STOP: begin
            TxOut    <= LINE_IDLE;
            stop_cnt <= (state == STOP) ? ~stop_cnt : 1'b0;
          end
          default: TxOut <= LINE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baud_serial_tx.sv
// Bench: four transmitter configurations, each paced by its own even-period generator model,
// with a per-instance scoreboard of expected line bits checked at every tick.
module tb_baud_serial_tx;

  localparam int NDUT = 4;
  localparam int NCFG  [NDUT] = '{4, 4, 4, 2};
  localparam int PECFG [NDUT] = '{0, 1, 1, 0};
  localparam int POCFG [NDUT] = '{0, 0, 1, 0};
  localparam int SBCFG [NDUT] = '{1, 1, 1, 2};

  logic       Clock = 1'b0;
  logic       Reset;
  logic       txvalid [NDUT];
  logic [7:0] txdata  [NDUT];
  logic       gen_en  [NDUT];
  logic       txout_w [NDUT];
  logic       rdy_w   [NDUT];
  logic       busy_w  [NDUT];
  logic       baud_w  [NDUT];
  int         popped_w[NDUT];
  int         lerr_w  [NDUT];
  int         rerr_w  [NDUT];
  int         berr_w  [NDUT];
  int         qlen_w  [NDUT];

  int n_chk = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < NDUT; gi++) begin : g
    localparam int N  = NCFG[gi];
    localparam int PE = PECFG[gi];
    localparam int PO = POCFG[gi];
    localparam int SB = SBCFG[gi];

    logic       baud;
    logic       txout;
    logic       txready;
    logic       busy;
    int         cnt;
    bit         q[$];
    bit         sq[$];
    logic       tick_p, acc_p, bprev, slot, in_frame, ready_exp, e, s;
    logic [7:0] dat_p;
    int         bits_seen, line_err, ready_err, busy_err;

    always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        baud <= 1'b0;
        cnt  <= 0;
      end else if (gen_en[gi]) begin
        if (cnt == N / 2 - 1) begin
          baud <= ~baud;
          cnt  <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end

    baud_serial_tx #(
      .DATA_BITS (8),
      .STOP_BITS (SB),
      .PARITY_EN (PE),
      .PARITY_ODD(PO)
    ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .BaudClk(baud),
      .TxData (txdata[gi]),
      .TxValid(txvalid[gi]),
      .TxReady(txready),
      .TxOut  (txout),
      .Busy   (busy)
    );

    // Each negedge settles what happened at the previous posedge: tick first, then accept.
    always @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
        q.delete();
        sq.delete();
        tick_p    = 1'b0;
        acc_p     = 1'b0;
        bprev     = 1'b0;
        slot      = 1'b1;
        in_frame  = 1'b0;
        ready_exp = 1'b1;
        dat_p     = 8'h00;
        if (bits_seen < 0 || $isunknown(bits_seen)) bits_seen = 0;
      end else begin
        if (tick_p) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            s = sq.pop_front();
            chk($sformatf("d%0d_bit%0d", gi, bits_seen), txout, e);
            bits_seen++;
            slot     = e;
            in_frame = 1'b1;
            if (s) ready_exp = 1'b1;
          end else begin
            slot     = 1'b1;
            in_frame = 1'b0;
            if (txout !== 1'b1) line_err++;
          end
        end else if (txout !== slot) begin
          line_err++;
        end
        if (acc_p) begin
          q.push_back(1'b0);
          sq.push_back(1'b1);
          for (int k = 0; k < 8; k++) begin
            q.push_back(dat_p[k]);
            sq.push_back(1'b0);
          end
          if (PE != 0) begin
            q.push_back((^dat_p) ^ (PO != 0));
            sq.push_back(1'b0);
          end
          for (int k = 0; k < SB; k++) begin
            q.push_back(1'b1);
            sq.push_back(1'b0);
          end
          ready_exp = 1'b0;
        end
        if (txready !== ready_exp) ready_err++;
        if (busy !== (in_frame || !ready_exp)) busy_err++;
        tick_p = baud && !bprev;
        bprev  = baud;
        acc_p  = txvalid[gi] && txready;
        dat_p  = txdata[gi];
      end
    end

    initial begin
      bits_seen = 0;
      line_err  = 0;
      ready_err = 0;
      busy_err  = 0;
    end

    assign txout_w[gi]  = txout;
    assign rdy_w[gi]    = txready;
    assign busy_w[gi]   = busy;
    assign baud_w[gi]   = baud;
    assign popped_w[gi] = bits_seen;
    assign lerr_w[gi]   = line_err;
    assign rerr_w[gi]   = ready_err;
    assign berr_w[gi]   = busy_err;
    assign qlen_w[gi]   = q.size();
  end

  // Callers start and end at posedge+1.
  task automatic send(input int idx, input logic [7:0] b);
    int   bud = 3000;
    logic acc = 1'b0;
    txvalid[idx] = 1'b1;
    txdata[idx]  = b;
    while (!acc && bud > 0) begin
      @(negedge Clock);
      acc = rdy_w[idx];
      @(posedge Clock);
      #1;
      bud--;
    end
    txvalid[idx] = 1'b0;
    chk($sformatf("d%0d_accept_%0h", idx, b), acc, 1'b1);
  endtask

  task automatic wait_idle(input int idx);
    int bud = 3000;
    while (busy_w[idx] && bud > 0) begin
      @(posedge Clock);
      #1;
      bud--;
    end
    chk($sformatf("d%0d_idle_in_time", idx), bud > 0, 1'b1);
    chk($sformatf("d%0d_idle_line", idx), txout_w[idx], 1'b1);
    chk($sformatf("d%0d_idle_ready", idx), rdy_w[idx], 1'b1);
  endtask

  int   p0;
  int   bud;
  logic prev;

  initial begin
    Reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      txvalid[i] = 1'b0;
      txdata[i]  = 8'h00;
      gen_en[i]  = 1'b1;
    end
    repeat (3) @(posedge Clock);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d_rst_line", i), txout_w[i], 1'b1);
      chk($sformatf("d%0d_rst_ready", i), rdy_w[i], 1'b1);
      chk($sformatf("d%0d_rst_busy", i), busy_w[i], 1'b0);
    end
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;

    p0 = popped_w[0];
    send(0, 8'hA5);
    wait_idle(0);
    chk("a5_bits", popped_w[0] - p0, 10);

    p0 = popped_w[0];
    send(0, 8'h00);
    send(0, 8'hFF);
    wait_idle(0);
    chk("b2b_bits", popped_w[0] - p0, 20);

    p0 = popped_w[1];
    send(1, 8'h07);
    wait_idle(1);
    chk("par_even_bits", popped_w[1] - p0, 11);
    p0 = popped_w[2];
    send(2, 8'h07);
    wait_idle(2);
    chk("par_odd_bits", popped_w[2] - p0, 11);

    // Reset while data bit 3 of 0x3C is on the line.
    p0 = popped_w[0];
    send(0, 8'h3C);
    bud = 500;
    while (popped_w[0] < p0 + 5 && bud > 0) begin
      @(posedge Clock);
      #1;
      bud--;
    end
    chk("rst_mid_reached", bud > 0, 1'b1);
    Reset = 1'b0;
    #1;
    chk("rst_mid_line", txout_w[0], 1'b1);
    chk("rst_mid_ready", rdy_w[0], 1'b1);
    chk("rst_mid_busy", busy_w[0], 1'b0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    p0 = popped_w[0];
    send(0, 8'h81);
    wait_idle(0);
    chk("post_rst_bits", popped_w[0] - p0, 10);

    // Stall the generator low just after a falling edge.
    prev = baud_w[0];
    bud  = 100;
    while (!(prev && !baud_w[0]) && bud > 0) begin
      prev = baud_w[0];
      @(posedge Clock);
      #1;
      bud--;
    end
    gen_en[0] = 1'b0;
    p0 = popped_w[0];
    send(0, 8'h55);
    txvalid[0] = 1'b1;
    txdata[0]  = 8'hAA;
    repeat (20) @(posedge Clock);
    #1;
    chk("stall_ready", rdy_w[0], 1'b0);
    chk("stall_line", txout_w[0], 1'b1);
    chk("stall_busy", busy_w[0], 1'b1);
    chk("stall_no_bits", popped_w[0] - p0, 0);
    txvalid[0] = 1'b0;
    gen_en[0]  = 1'b1;
    wait_idle(0);
    chk("stall_bits", popped_w[0] - p0, 10);

    p0 = popped_w[3];
    send(3, 8'h96);
    send(3, 8'h3B);
    wait_idle(3);
    chk("stop2_bits", popped_w[3] - p0, 22);

    repeat (4) @(posedge Clock);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d_line_stable_errs", i), lerr_w[i], 0);
      chk($sformatf("d%0d_ready_errs", i), rerr_w[i], 0);
      chk($sformatf("d%0d_busy_errs", i), berr_w[i], 0);
      chk($sformatf("d%0d_queue_left", i), qlen_w[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/baud_serial_tx.md
# baud_serial_tx

Serial transmitter that consumes the square wave from the even-period clock generator as its bit-rate reference. It runs entirely in the system `Clock` domain and treats the generator output as a data signal, not a clock: each rising edge of `BaudClk` is one bit-time tick. Bytes arrive over a valid/ready handshake into a one-entry holding register and leave LSB-first as start/data/optional-parity/stop frames on `TxOut`.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `Clock`  input  1  system clock; also clocks the upstream generator.
- `Reset`  input  1  asynchronous, active-low reset.
- `BaudClk`  input  1  generator `OUT`; period N `Clock` cycles, registered in the `Clock` domain.
- `TxData`  input  DATA_BITS  byte to send.
- `TxValid`  input  1  `TxData` is valid.
- `TxReady`  output  1  holding register empty; the byte is accepted when `TxValid`&&`TxReady` at a `Clock` edge.
- `TxOut`  output  1  serial line; idles high.
- `Busy`  output  1  frame in progress or holding register full.

## Operation
- Tick = `BaudClk` & ~`baud_q`, where `baud_q` is `BaudClk` delayed by one `Clock`. `baud_q` resets to 0.
- `BaudClk` is synchronous to `Clock`, so there is no synchronizer.
- States:
  - IDLE: `TxOut`=1.
  - START: `TxOut`=0.
  - DATA: `TxOut`=shift[0], LSB first, for DATA_BITS ticks.
  - PARITY: `TxOut`=^data XOR `PARITY_ODD`; present only if `PARITY_EN`.
  - STOP: `TxOut`=1, for STOP_BITS ticks.
- Transitions occur only on tick edges. The only exception is reset.
- IDLE→START: on a tick with the holding register full. The holding register loads into the shift register and is marked empty.
- START→DATA, DATA→PARITY or STOP (after the last data bit), PARITY→STOP: each on a tick.
- End of the last stop bit, on a tick:
  - holding register full: go to START, loading the next byte. Frames are back-to-back with no idle bit.
  - otherwise: go to IDLE.
- Bit counter width is $clog2(DATA_BITS+1). The stop counter is 1 bit. Counters clear on entry to each state.
- Accept and consume never coincide: accept requires the holding register empty, consume requires it full.
- `BaudClk` stalled at either level: no ticks, so state, `TxOut` and the holding register all freeze. This is legal and not an error.
- Reset, asynchronous, including mid-frame: state=IDLE, holding register empty, all counters 0. The partial frame is abandoned.
- Reset values: `TxOut`=1, `TxReady`=1, `Busy`=0, `baud_q`=0.

## Timing
- `TxOut`, `TxReady` and `Busy` are registered outputs.
- Each line bit lasts exactly N `Clock` cycles, tick to tick.
- `TxOut` changes on the `Clock` edge where the tick is high, i.e. one cycle after `BaudClk` becomes 1.
- Acceptance:
  - `TxReady` falls on the cycle after acceptance.
  - It rises on the cycle after the tick that moves the byte into the shift register.
  - A tick on the same edge as acceptance does not start that byte.
- Start latency: first tick strictly after acceptance, so worst case N cycles plus one.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × N cycles.
- `Busy` rises with acceptance. It falls on the cycle after the IDLE transition, provided the holding register is empty.
- After reset, the generator's first toggle produces a tick on the second `Clock` edge after reset release.

## Structure
- Shared package `baud_serial_tx_pkg`:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - `LINE_IDLE`=1'b1 and `START_BIT`=1'b0 constants.
- Sub-module `baud_tick_detect`: `Clock`, `Reset`, `BaudClk` in; one-cycle `tick` out.
- Everything else is in one always block plus next-state logic.

## Test plan
- Setup for all cases: generator with N=4 drives `BaudClk`; defaults unless stated.
- Send 0xA5 → `TxOut` = 0, 1,0,1,0,0,1,0,1, 1. Each bit is exactly 4 cycles; `TxReady` is low from acceptance until the start-bit tick.
- Send 0x00, then 0xFF accepted during the first frame → 20 contiguous bit-times: 0, eight 0s, 1, 0, eight 1s, 1. There is no idle gap; `Busy` stays high throughout.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame is 11 bits (44 cycles).
- Assert `Reset` low during data bit 3 of 0x3C → `TxOut`=1 and `TxReady`=1 immediately. After release, a new byte 0x81 transmits a clean frame.
- Hold `BaudClk` low, then send 0x55 → `TxOut` stays 1 and a second `TxValid` is not accepted (`TxReady`=0). Releasing the generator starts the frame at the first rising edge.
- N=2 with STOP_BITS=2 → each bit lasts 2 cycles, stop is 4 cycles high, and a back-to-back second frame starts immediately after.
